// File: rtl/sram_1rw1r_model.sv
// Cycle-accurate 1RW + 1R SRAM model with post-reset clear sequencer and 1- or 2-cycle read latency.
// Define SRAM_RW_BYPASS_EN to make a colliding port-1 read return the post-write word.
module sram_1rw1r_model #(
  parameter int WORD_SIZE    = 32,
  parameter int NUM_WORDS    = 16,
  parameter int WRITE_SIZE   = 8,
  parameter int ADDR_WIDTH   = $clog2(NUM_WORDS),
  parameter int READ_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              ready,
  input  logic                              csb0,
  input  logic                              web0,
  input  logic [(WORD_SIZE/WRITE_SIZE)-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]             addr0,
  input  logic [WORD_SIZE-1:0]              din0,
  output logic [WORD_SIZE-1:0]              dout0,
  input  logic                              csb1,
  input  logic [ADDR_WIDTH-1:0]             addr1,
  output logic [WORD_SIZE-1:0]              dout1
);

  localparam int NUM_WMASKS = WORD_SIZE / WRITE_SIZE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $fatal(1, "sram_1rw1r_model: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clear_cnt, clear_cnt_nxt;
  logic                    clr_we;

  logic [WORD_SIZE-1:0]    mem [NUM_WORDS];

  logic                    wr_en, rd0_req, rd1_req;
  logic [WORD_SIZE-1:0]    rd0_word, rd1_word;
  logic [WORD_SIZE-1:0]    rd0_data_p0, rd1_data_p0;
  logic                    vld0_p0, vld1_p0;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < (ADDR_WIDTH+1)'(NUM_WORDS);
  endfunction

  function automatic logic [WORD_SIZE-1:0] merge_lanes(input logic [WORD_SIZE-1:0]  old_word,
                                                       input logic [WORD_SIZE-1:0]  new_word,
                                                       input logic [NUM_WMASKS-1:0] mask);
    logic [WORD_SIZE-1:0] res;
    res = old_word;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (mask[i]) res[i*WRITE_SIZE +: WRITE_SIZE] = new_word[i*WRITE_SIZE +: WRITE_SIZE];
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_CLEAR;
      clear_cnt <= '0;
    end else begin
      state     <= state_nxt;
      clear_cnt <= clear_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    clear_cnt_nxt = clear_cnt;
    clr_we        = 1'b0;
    case (state)
      S_CLEAR: begin
        clr_we = 1'b1;
        if (clear_cnt == LAST_ADDR) state_nxt = S_READY;
        else                        clear_cnt_nxt = clear_cnt + 1'b1;
      end
      S_READY: ;
      default: state_nxt = S_CLEAR;
    endcase
  end

  assign ready = (state == S_READY);

  assign wr_en   = ready & ~csb0 & ~web0 & in_range(addr0);
  assign rd0_req = ready & ~csb0 & web0;
  assign rd1_req = ready & ~csb1;

  // Array read; a port-1 hit on the in-flight write sees either the old or the merged word
  always_comb begin
    rd0_word = in_range(addr0) ? mem[addr0] : '0;
    rd1_word = in_range(addr1) ? mem[addr1] : '0;
`ifdef SRAM_RW_BYPASS_EN
    if (wr_en && (addr1 == addr0)) rd1_word = merge_lanes(mem[addr1], din0, wmask0);
`endif
  end

  always_ff @(posedge clk) begin
    if (clr_we)     mem[clear_cnt] <= '0;
    else if (wr_en) mem[addr0]     <= merge_lanes(mem[addr0], din0, wmask0);
  end

  // Stage p0: array output captured on the request edge
  always_ff @(posedge clk) begin
    if (rd0_req) rd0_data_p0 <= rd0_word;
    if (rd1_req) rd1_data_p0 <= rd1_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld0_p0 <= 1'b0;
      vld1_p0 <= 1'b0;
    end else begin
      vld0_p0 <= rd0_req;
      vld1_p0 <= rd1_req;
    end
  end

  // Output stage: dout only moves when a read lands, so it holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout0 <= '0;
      dout1 <= '0;
    end else if (READ_LATENCY == 1) begin
      if (rd0_req) dout0 <= rd0_word;
      if (rd1_req) dout1 <= rd1_word;
    end else begin
      if (vld0_p0) dout0 <= rd0_data_p0;
      if (vld1_p0) dout1 <= rd1_data_p0;
    end
  end

endmodule

// File: tb/tb_sram_1rw1r_model.sv
// Directed bench for sram_1rw1r_model: three instances (16 words lat 1, 16 words lat 2, 12 words lat 1)
// share one stimulus bus; each scenario task checks the instances it targets.
module tb_sram_1rw1r_model;

  logic        clk = 1'b0;
  logic        rst;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [3:0]  addr0, addr1;
  logic [31:0] din0;

  logic        ready_a, ready_b, ready_c;
  logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b, dout0_c, dout1_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_1rw1r_model #(.WORD_SIZE(32), .NUM_WORDS(16), .WRITE_SIZE(8), .READ_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .ready(ready_a), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0_a), .csb1(csb1), .addr1(addr1), .dout1(dout1_a));

  sram_1rw1r_model #(.WORD_SIZE(32), .NUM_WORDS(16), .WRITE_SIZE(8), .READ_LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .ready(ready_b), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0_b), .csb1(csb1), .addr1(addr1), .dout1(dout1_b));

  sram_1rw1r_model #(.WORD_SIZE(32), .NUM_WORDS(12), .WRITE_SIZE(8), .READ_LATENCY(1)) u_small (
    .clk(clk), .rst(rst), .ready(ready_c), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0_c), .csb1(csb1), .addr1(addr1), .dout1(dout1_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = 4'h0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); addr0 = '0; addr1 = '0; din0 = '0;
    #2;
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_a); end
    checks++; if (dout0_a !== 32'h0) begin errors++; $display("FAIL reset_dout0 got=%h exp=0", dout0_a); end
    checks++; if (dout1_a !== 32'h0) begin errors++; $display("FAIL reset_dout1 got=%h exp=0", dout1_a); end
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i <= 10) begin
        csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd2; din0 = 32'hFFFF_FFFF; wmask0 = 4'hF;
        csb1 = 1'b0; addr1 = 4'd2;
      end else begin
        idle();
      end
      tick();
      checks++;
      if (ready_a !== (i >= 16)) begin errors++; $display("FAIL clear_ready16 edge=%0d got=%b exp=%b", i, ready_a, (i >= 16)); end
      checks++;
      if (ready_c !== (i >= 12)) begin errors++; $display("FAIL clear_ready12 edge=%0d got=%b exp=%b", i, ready_c, (i >= 12)); end
      if (i <= 10) begin
        checks++;
        if (dout0_a !== 32'h0 || dout1_a !== 32'h0) begin
          errors++; $display("FAIL clear_dout_hold edge=%0d got=%h/%h exp=0/0", i, dout0_a, dout1_a);
        end
      end
    end
    idle();
  endtask

  task automatic test_clear_reads();
    for (int i = 0; i < 16; i++) begin
      csb0 = 1'b0; web0 = 1'b1; addr0 = 4'(i);
      csb1 = 1'b0; addr1 = 4'(15 - i);
      tick();
      checks++;
      if (dout0_a !== 32'h0 || dout1_a !== 32'h0) begin
        errors++; $display("FAIL cleared_read i=%0d got=%h/%h exp=0/0", i, dout0_a, dout1_a);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    do_write(4'd3, 32'hA5A5_A5A5, 4'hF);
    checks++; if (dout0_a !== 32'h0) begin errors++; $display("FAIL write_holds_dout0 got=%h exp=0", dout0_a); end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3;
    tick();
    idle();
    checks++; if (dout0_a !== 32'hA5A5_A5A5) begin errors++; $display("FAIL read_lat1 got=%h exp=a5a5a5a5", dout0_a); end
    checks++; if (dout0_b !== 32'h0) begin errors++; $display("FAIL read_lat2_early got=%h exp=0", dout0_b); end
    tick();
    checks++; if (dout0_b !== 32'hA5A5_A5A5) begin errors++; $display("FAIL read_lat2 got=%h exp=a5a5a5a5", dout0_b); end
    checks++; if (dout0_a !== 32'hA5A5_A5A5) begin errors++; $display("FAIL dout0_hold got=%h exp=a5a5a5a5", dout0_a); end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3; csb1 = 1'b0; addr1 = 4'd3;
    tick();
    idle();
    checks++;
    if (dout0_a !== 32'hA5A5_A5A5 || dout1_a !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL same_addr_both got=%h/%h exp=a5a5a5a5", dout0_a, dout1_a);
    end
  endtask

  task automatic test_mask();
    do_write(4'd5, 32'h1122_3344, 4'hF);
    do_write(4'd5, 32'hFFFF_FFFF, 4'b0101);
    csb1 = 1'b0; addr1 = 4'd5;
    tick();
    idle();
    checks++; if (dout1_a !== 32'h11FF_33FF) begin errors++; $display("FAIL mask_0101 got=%h exp=11ff33ff", dout1_a); end
    do_write(4'd5, 32'h0000_0000, 4'h0);
    do_write(4'd5, 32'hAAAA_AAAA, 4'b1000);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd5;
    tick();
    idle();
    checks++; if (dout0_a !== 32'hAAFF_33FF) begin errors++; $display("FAIL mask_noop_then_1000 got=%h exp=aaff33ff", dout0_a); end
  endtask

  task automatic test_collision();
    logic [31:0] exp_coll;
`ifdef SRAM_RW_BYPASS_EN
    exp_coll = 32'hDEAD_BEEF;
`else
    exp_coll = 32'h0000_0000;
`endif
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd7; din0 = 32'hDEAD_BEEF; wmask0 = 4'hF;
    csb1 = 1'b0; addr1 = 4'd7;
    tick();
    idle();
    checks++; if (dout1_a !== exp_coll) begin errors++; $display("FAIL collision_dout1 got=%h exp=%h", dout1_a, exp_coll); end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd7;
    tick();
    idle();
    checks++; if (dout0_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL collision_written got=%h exp=deadbeef", dout0_a); end
  endtask

  task automatic test_back_to_back();
    do_write(4'd0, 32'h0000_0100, 4'hF);
    do_write(4'd1, 32'h0000_0111, 4'hF);
    do_write(4'd2, 32'h0000_0222, 4'hF);
    csb1 = 1'b0; addr1 = 4'd0;
    tick();
    checks++; if (dout1_a !== 32'h100) begin errors++; $display("FAIL b2b_lat1_e1 got=%h exp=100", dout1_a); end
    addr1 = 4'd1;
    tick();
    checks++; if (dout1_a !== 32'h111) begin errors++; $display("FAIL b2b_lat1_e2 got=%h exp=111", dout1_a); end
    checks++; if (dout1_b !== 32'h100) begin errors++; $display("FAIL b2b_lat2_e2 got=%h exp=100", dout1_b); end
    addr1 = 4'd2;
    tick();
    idle();
    checks++; if (dout1_a !== 32'h222) begin errors++; $display("FAIL b2b_lat1_e3 got=%h exp=222", dout1_a); end
    checks++; if (dout1_b !== 32'h111) begin errors++; $display("FAIL b2b_lat2_e3 got=%h exp=111", dout1_b); end
    tick();
    checks++; if (dout1_b !== 32'h222) begin errors++; $display("FAIL b2b_lat2_e4 got=%h exp=222", dout1_b); end
    tick();
    checks++; if (dout1_b !== 32'h222) begin errors++; $display("FAIL b2b_lat2_hold got=%h exp=222", dout1_b); end
  endtask

  task automatic test_out_of_range();
    do_write(4'd13, 32'h1234_5678, 4'hF);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd13; csb1 = 1'b0; addr1 = 4'd13;
    tick();
    idle();
    checks++; if (dout0_c !== 32'h0) begin errors++; $display("FAIL oor_read0 got=%h exp=0", dout0_c); end
    checks++; if (dout1_c !== 32'h0) begin errors++; $display("FAIL oor_read1 got=%h exp=0", dout1_c); end
    checks++; if (dout0_a !== 32'h1234_5678) begin errors++; $display("FAIL inrange_13 got=%h exp=12345678", dout0_a); end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd11;
    tick();
    idle();
    checks++; if (dout0_c !== 32'h0) begin errors++; $display("FAIL last_word_12 got=%h exp=0", dout0_c); end
  endtask

  task automatic test_reset_mid_clear();
    rst = 1'b1;
    #1;
    checks++; if (ready_a !== 1'b0 || ready_c !== 1'b0) begin errors++; $display("FAIL async_ready got=%b/%b exp=0/0", ready_a, ready_c); end
    checks++; if (dout0_a !== 32'h0) begin errors++; $display("FAIL async_dout0 got=%h exp=0", dout0_a); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    checks++; if (ready_c !== 1'b0) begin errors++; $display("FAIL midclear_ready got=%b exp=0", ready_c); end
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (ready_c !== (i >= 12)) begin errors++; $display("FAIL restart_ready12 edge=%0d got=%b exp=%b", i, ready_c, (i >= 12)); end
      checks++;
      if (ready_a !== (i >= 16)) begin errors++; $display("FAIL restart_ready16 edge=%0d got=%b exp=%b", i, ready_a, (i >= 16)); end
    end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3; csb1 = 1'b0; addr1 = 4'd13;
    tick();
    idle();
    checks++;
    if (dout0_a !== 32'h0 || dout1_a !== 32'h0) begin
      errors++; $display("FAIL recleared got=%h/%h exp=0/0", dout0_a, dout1_a);
    end
  endtask

  initial begin
    test_reset();
    test_clear_reads();
    test_write_read();
    test_mask();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
